karatsuba_pipe: RTL

- Parametrised, pipelined Karatsuba multiplier, successor to the fixed 32-bit combinational Karatsuba block.
- Width-generic, registered 3-stage datapath with valid/ready handshake on both sides, plus a per-operation tag.
- Sits between operand producers and accumulators in the multiplier test fabric.
- Can optionally run an approximate mode on low/middle partial products.

---
 rtl/karatsuba_pkg.sv | 26 ++
 rtl/karatsuba_if.sv | 39 +++
 rtl/karatsuba_mul_core.sv | 24 ++
 rtl/karatsuba_pipe.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/karatsuba_pkg.sv
// Shared widths, mode encoding and default parameters
// for the karatsuba_pipe multiplier slice.
package karatsuba_pkg;

    localparam int N_DEF        = 32;
    localparam int TAG_W_DEF    = 4;
    localparam int APPROX_T_DEF = 4;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_e;

    function automatic int half_w(input int n);
        return n / 2;
    endfunction

    function automatic int sum_w(input int n);
        return n / 2 + 1;
    endfunction

    function automatic int prod_w(input int w1, input int w2);
        return w1 + w2;
    endfunction

endpackage

// File: rtl/karatsuba_if.sv
// Operand/result handshake bundle for karatsuba_pipe.
// in_approx exists only when KARATSUBA_APPROX_EN is defined.
interface karatsuba_if #(
    parameter int N     = karatsuba_pkg::N_DEF,
    parameter int TAG_W = karatsuba_pkg::TAG_W_DEF
) ();

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [TAG_W-1:0] in_tag;
`ifdef KARATSUBA_APPROX_EN
    logic             in_approx;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_p;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_tag,
`ifdef KARATSUBA_APPROX_EN
        output in_approx,
`endif
        output out_ready,
        input  in_ready, out_valid, out_p, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_tag,
`ifdef KARATSUBA_APPROX_EN
        input  in_approx,
`endif
        input  out_ready,
        output in_ready, out_valid, out_p, out_tag
    );

endinterface

// File: rtl/karatsuba_mul_core.sv
// Unsigned W1 x W2 multiplier with a registered, enabled output.
// Drop-in slot for the radix-4 multiplier variants.
module karatsuba_mul_core
    import karatsuba_pkg::*;
#(
    parameter int W1 = 16,
    parameter int W2 = 16
) (
    input  logic                       clk,
    input  logic                       en,
    input  logic [W1-1:0]              a,
    input  logic [W2-1:0]              b,
    output logic [prod_w(W1, W2)-1:0]  p
);

    localparam int PW = prod_w(W1, W2);

    always_ff @(posedge clk) begin
        if (en) begin
            p <= PW'(a) * PW'(b);
        end
    end

endmodule

// File: rtl/karatsuba_pipe.sv
// 3-stage pipelined Karatsuba multiplier with valid/ready and tags.
// Define KARATSUBA_APPROX_EN for the approximate low/middle mode.
module karatsuba_pipe
    import karatsuba_pkg::*;
#(
    parameter int N        = N_DEF,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int APPROX_T = APPROX_T_DEF
) (
    input  logic       clk,
    input  logic       rst,
    karatsuba_if.slave bus,
    output logic       busy
);

    localparam int K  = half_w(N);
    localparam int SW = sum_w(N);
    localparam int MW = prod_w(SW, SW);
    localparam int PW = prod_w(N, N);

    if (N % 2 != 0 || N < 8 || APPROX_T < 0 || APPROX_T >= K) begin : g_bad_param
        $error("karatsuba_pipe: need even N >= 8 and 0 <= APPROX_T < N/2");
    end

    logic v1, v2, v3;
    logic ld1, ld2, ld3;
    logic acc, ld_mul, ld_out;

    // A stage loads when empty or when its content moves on.
    assign ld3    = !v3 || bus.out_ready;
    assign ld2    = !v2 || ld3;
    assign ld1    = !v1 || ld2;
    assign acc    = bus.in_valid && ld1;
    assign ld_mul = ld2 && v1;
    assign ld_out = ld3 && v2;

    logic [K-1:0]     ah, al, bh, bl;
    logic [SW-1:0]    s1, s2;
    logic [TAG_W-1:0] tag1, tag2, tag_q;
    logic [PW-1:0]    p_q, p_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            v1 <= 1'b0;
        end else if (ld1) begin
            v1 <= bus.in_valid;
        end
        if (acc) begin
            ah   <= bus.in_a[N-1:K];
            al   <= bus.in_a[K-1:0];
            bh   <= bus.in_b[N-1:K];
            bl   <= bus.in_b[K-1:0];
            s1   <= SW'(bus.in_a[N-1:K]) + SW'(bus.in_a[K-1:0]);
            s2   <= SW'(bus.in_b[N-1:K]) + SW'(bus.in_b[K-1:0]);
            tag1 <= bus.in_tag;
        end
    end

    logic [K-1:0]  al_m, bl_m;
    logic [SW-1:0] s1_m, s2_m;

`ifdef KARATSUBA_APPROX_EN
    localparam logic [SW-1:0] MASK_S = {SW{1'b1}} << APPROX_T;
    localparam logic [K-1:0]  MASK_H = MASK_S[K-1:0];

    mode_e mode1;

    always_ff @(posedge clk) begin
        if (acc) begin
            mode1 <= mode_e'(bus.in_approx);
        end
    end

    // High halves stay exact; only low/middle operands lose bits.
    always_comb begin
        al_m = al;
        bl_m = bl;
        s1_m = s1;
        s2_m = s2;
        if (mode1 == MODE_APPROX) begin
            al_m = al & MASK_H;
            bl_m = bl & MASK_H;
            s1_m = s1 & MASK_S;
            s2_m = s2 & MASK_S;
        end
    end
`else
    assign al_m = al;
    assign bl_m = bl;
    assign s1_m = s1;
    assign s2_m = s2;
`endif

    logic [2*K-1:0] m1, m2;
    logic [MW-1:0]  m3;

    karatsuba_mul_core #(.W1(K), .W2(K)) u_m1 (
        .clk(clk), .en(ld_mul), .a(ah), .b(bh), .p(m1)
    );

    karatsuba_mul_core #(.W1(K), .W2(K)) u_m2 (
        .clk(clk), .en(ld_mul), .a(al_m), .b(bl_m), .p(m2)
    );

    karatsuba_mul_core #(.W1(SW), .W2(SW)) u_m3 (
        .clk(clk), .en(ld_mul), .a(s1_m), .b(s2_m), .p(m3)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            v2 <= 1'b0;
        end else if (ld2) begin
            v2 <= v1;
        end
        if (ld_mul) begin
            tag2 <= tag1;
        end
    end

    logic [MW-1:0] m12, mid;

    always_comb begin
        m12 = MW'(m1) + MW'(m2);
`ifdef KARATSUBA_APPROX_EN
        mid = (m3 >= m12) ? (m3 - m12) : (m12 - m3);
`else
        mid = m3 - m12;
`endif
        p_nx = (PW'(m1) << N) + (PW'(mid) << K) + PW'(m2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v3    <= 1'b0;
            p_q   <= '0;
            tag_q <= '0;
        end else begin
            if (ld3) begin
                v3 <= v2;
            end
            if (ld_out) begin
                p_q   <= p_nx;
                tag_q <= tag2;
            end
        end
    end

    assign bus.in_ready  = ld1;
    assign bus.out_valid = v3;
    assign bus.out_p     = p_q;
    assign bus.out_tag   = tag_q;
    assign busy          = v1 | v2 | v3;

endmodule
